// File: rtl/control_defs.sv
// Shared definitions for the ALU arbiter and related arbiters.
// Holds the ALU select encoding, requester limit and request bundle type.
package control_defs;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3
    } alu_sel_e;

    localparam int ALU_ARB_MAX_REQ = 8;

    typedef struct packed {
        alu_sel_e    sel;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Searches the request vector cyclically starting at the pointer.
module rr_pick #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // First set request at or after the pointer, wrapping around
    always_comb begin : p_pick
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among requesters.
// Define ALU_ARB_LOCK_EN to add req_lock for locked multi-op sequences.
module alu_arbiter
    import control_defs::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] req_lock,
`endif
    output logic [NUM_REQ-1:0] req_ready,
    input  alu_sel_e           req_sel [NUM_REQ],
    input  logic [31:0]        req_a   [NUM_REQ],
    input  logic [31:0]        req_b   [NUM_REQ],
    output alu_sel_e           alu_sel,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic [31:0]        resp_result,
    output logic               resp_zero
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
            $error("alu_arbiter: NUM_REQ out of range");
        end
    endgenerate

    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [31:0]        r_resp_result;
    logic               r_resp_zero;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_can_issue;
    logic [NUM_REQ-1:0] w_req_mask;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [ID_W-1:0]    w_rr_idx;
    logic               w_rr_any;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_any;
    logic               w_adv_ptr;
    logic [ID_W-1:0]    w_ptr_next;
    alu_req_t           w_pick;

    // Issue only when the output register is free or draining now;
    // nothing is accepted while reset is held.
    assign w_can_issue = !r_resp_valid || resp_ready;
    assign w_req_mask  = (rst_n && w_can_issue) ? req_valid : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (w_req_mask),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_rr_gnt),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

`ifdef ALU_ARB_LOCK_EN
    logic               r_lock_active;
    logic [ID_W-1:0]    r_lock_owner;
    logic               w_lock_hit;

    // A locked owner that is requesting again overrides round-robin
    always_comb begin
        w_lock_hit = 1'b0;
        w_gnt_oh   = w_rr_gnt;
        w_gnt_idx  = w_rr_idx;
        w_gnt_any  = w_rr_any;
        w_adv_ptr  = w_rr_any;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_lock_active && int'(r_lock_owner) == i && w_req_mask[i]) begin
                w_lock_hit = 1'b1;
            end
        end
        if (w_lock_hit) begin
            w_gnt_oh = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (int'(r_lock_owner) == i) begin
                    w_gnt_oh[i] = 1'b1;
                end
            end
            w_gnt_idx = r_lock_owner;
            w_gnt_any = 1'b1;
            w_adv_ptr = 1'b0;
        end
    end

    // Track lock ownership: set by a locked grant, cleared when the
    // owner is not requesting on an issue cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= '0;
        end else if (w_gnt_any) begin
            r_lock_active <= |(w_gnt_oh & req_lock);
            r_lock_owner  <= w_gnt_idx;
        end else if (w_can_issue) begin
            r_lock_active <= 1'b0;
        end
    end
`else
    // Pure round-robin grant
    always_comb begin
        w_gnt_oh  = w_rr_gnt;
        w_gnt_idx = w_rr_idx;
        w_gnt_any = w_rr_any;
        w_adv_ptr = w_rr_any;
    end
`endif

    assign req_ready = w_gnt_oh;

    // Mux the granted request onto the ALU; idle drive is AND 0,0
    always_comb begin
        w_pick = '{sel: ALU_AND, a: '0, b: '0};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_pick = '{sel: req_sel[i], a: req_a[i], b: req_b[i]};
            end
        end
    end

    assign alu_sel = w_pick.sel;
    assign alu_a   = w_pick.a;
    assign alu_b   = w_pick.b;

    assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ?
                        '0 : w_gnt_idx + ID_W'(1);

    // Pointer moves past the winner on round-robin grants only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_adv_ptr) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // Output register: load on grant, empty on drain without a grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else if (w_gnt_any) begin
            r_resp_valid  <= 1'b1;
            r_resp_id     <= w_gnt_idx;
            r_resp_result <= alu_result;
            r_resp_zero   <= alu_zero;
        end else if (resp_ready) begin
            r_resp_valid  <= 1'b0;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with three requesters.
// Also exercises the lock path when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
    import control_defs::*;

    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    alu_sel_e       req_sel [N];
    logic [31:0]    req_a   [N];
    logic [31:0]    req_b   [N];
    alu_sel_e       alu_sel;
    logic [31:0]    alu_a;
    logic [31:0]    alu_b;
    logic [31:0]    alu_result;
    logic           alu_zero;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [31:0]    resp_result;
    logic           resp_zero;

    int n_checks;
    int n_errors;

    alu_arbiter #(
        .NUM_REQ     (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
`ifdef ALU_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU attached to the arbiter
    always_comb begin
        case (alu_sel)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input alu_sel_e s,
                           input logic [31:0] a, input logic [31:0] b);
        req_sel[i] = s;
        req_a[i]   = a;
        req_b[i]   = b;
    endtask

    task automatic chk_resp(input string tag, input logic v,
                            input int id, input logic [31:0] r,
                            input logic z);
        chk({tag, "_valid"},  32'(resp_valid),  32'(v));
        chk({tag, "_id"},     32'(resp_id),     32'(id));
        chk({tag, "_result"}, resp_result,      r);
        chk({tag, "_zero"},   32'(resp_zero),   32'(z));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        req_valid  = 3'b011;
        req_lock   = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, ALU_AND, 32'd0, 32'd0);

        // Reset held with requests pending
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk_resp("rst", 1'b0, 0, 32'd0, 1'b0);

        // Release: first grant goes to req0 (ADD 5+7)
        rst_n = 1'b1;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        set_req(1, ALU_OR, 32'hF0, 32'h0F);
        #1;
        chk("first_ready", 32'(req_ready), 32'b001);
        chk("first_sel", 32'(alu_sel), 32'(ALU_ADD));
        chk("first_a", alu_a, 32'd5);
        chk("first_b", alu_b, 32'd7);
        tick();
        chk_resp("add", 1'b1, 0, 32'd12, 1'b0);

        // Contention: alternate req1, req0, req1
        set_req(0, ALU_SUB, 32'd3, 32'd3);
        #1;
        chk("cont1_ready", 32'(req_ready), 32'b010);
        tick();
        chk_resp("cont1", 1'b1, 1, 32'hFF, 1'b0);
        chk("cont2_ready", 32'(req_ready), 32'b001);
        tick();
        chk_resp("cont2", 1'b1, 0, 32'd0, 1'b1);
        chk("cont3_ready", 32'(req_ready), 32'b010);
        tick();
        chk_resp("cont3", 1'b1, 1, 32'hFF, 1'b0);

        // Backpressure: held response, no grants, idle ALU drive
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_alu_a", alu_a, 32'd0);
            tick();
            chk_resp("bp", 1'b1, 1, 32'hFF, 1'b0);
        end

        // Drain and reload in the same cycle: ptr=2 -> req0
        resp_ready = 1'b1;
        #1;
        chk("reload_ready", 32'(req_ready), 32'b001);
        tick();
        chk_resp("reload", 1'b1, 0, 32'd0, 1'b1);

        // Drain without a new grant
        req_valid = 3'b000;
        #1;
        chk("drain_ready", 32'(req_ready), 32'd0);
        tick();
        chk("drain_valid", 32'(resp_valid), 32'd0);

        // Wrap: ptr=1, only req2 valid
        req_valid = 3'b100;
        set_req(2, ALU_ADD, 32'd1, 32'd2);
        #1;
        chk("wrap2_ready", 32'(req_ready), 32'b100);
        tick();
        chk_resp("wrap2", 1'b1, 2, 32'd3, 1'b0);

        // ptr wrapped to 0: req0 beats req2
        req_valid = 3'b101;
        set_req(0, ALU_OR, 32'h10, 32'h01);
        #1;
        chk("wrap0_ready", 32'(req_ready), 32'b001);
        tick();
        chk_resp("wrap0", 1'b1, 0, 32'h11, 1'b0);

        // Unknown select passes through; ALU default gives 0
        req_valid = 3'b001;
        set_req(0, alu_sel_e'(3'd5), 32'h1234, 32'h5678);
        #1;
        chk("odd_sel", 32'(alu_sel), 32'd5);
        tick();
        chk_resp("odd", 1'b1, 0, 32'd0, 1'b1);

        // Reset mid-op: pending response dropped, ptr back to 0
        req_valid  = 3'b000;
        resp_ready = 1'b0;
        tick();
        chk("pend_valid", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_resp("midrst", 1'b0, 0, 32'd0, 1'b0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 3'b011;
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        #1;
        chk("postrst_ready", 32'(req_ready), 32'b001);
        tick();
        chk_resp("postrst", 1'b1, 0, 32'd30, 1'b0);

`ifdef ALU_ARB_LOCK_EN
        // Lock: req1 wins via ptr=1 with lock set
        req_lock = 3'b010;
        #1;
        chk("lock1_ready", 32'(req_ready), 32'b010);
        tick();
        chk_resp("lock1", 1'b1, 1, 32'd2, 1'b0);

        // ptr=2 would pick req0, but lock re-grants req1
        req_lock = 3'b000;
        set_req(1, ALU_ADD, 32'd2, 32'd2);
        #1;
        chk("lock2_ready", 32'(req_ready), 32'b010);
        tick();
        chk_resp("lock2", 1'b1, 1, 32'd4, 1'b0);

        // Released; ptr still 2 so req0 wins
        #1;
        chk("unlock_ready", 32'(req_ready), 32'b001);
        tick();
        chk_resp("unlock", 1'b1, 0, 32'd30, 1'b0);
`endif

        req_valid = 3'b000;
        tick();
        chk("final_valid", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
